// File: rtl/hex_bcd_display_encoder_pkg.sv
// Shared types and constants for the binary-to-BCD 7-segment display encoder.
package hex_bcd_display_encoder_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, ENCODE} state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    // Active-low patterns, bit 0 = segment a ... bit 6 = segment g
    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) r = r * 64'd10;
        return r;
    endfunction

endpackage

// File: rtl/hex_bcd_display_encoder_if.sv
// Upstream value handshake plus the registered display-side outputs.
interface hex_bcd_display_encoder_if #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 4
);
    logic                  in_valid;
    logic                  in_ready;
    logic [WIDTH-1:0]      in_value;
    logic                  blank_lz;
    logic [7*DIGITS-1:0]   seg_out;
    logic                  out_valid;
    logic                  overflow;

    modport master (
        output in_valid, in_value, blank_lz,
        input  in_ready, seg_out, out_valid, overflow
    );

    modport slave (
        input  in_valid, in_value, blank_lz,
        output in_ready, seg_out, out_valid, overflow
    );
endinterface

// File: rtl/hex_bcd_display_encoder_seg7_encode.sv
// One BCD nibble to an active-low 7-segment pattern; non-decimal nibbles show blank.
module seg7_encode
    import hex_bcd_display_encoder_pkg::*;
(
    input  logic [3:0] nib_i,
    input  logic       blank_i,
    output logic [6:0] seg_o
);
    always_comb begin
        seg_o = SEG_BLANK;
        if (!blank_i && nib_i <= 4'd9) seg_o = SEG_DIGIT[nib_i];
    end
endmodule

// File: rtl/hex_bcd_display_encoder.sv
// Sequential double-dabble conversion of one value per handshake into a
// registered active-low segment word with leading-zero blanking and over-range dashes.
module hex_bcd_display_encoder
    import hex_bcd_display_encoder_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    hex_bcd_display_encoder_if.slave  bus
);
    localparam int          BW      = 4 * DIGITS;
    localparam int          CW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [63:0] MAX_VAL = pow10(DIGITS) - 64'd1;

    state_t              state_q, state_d;
    logic [WIDTH-1:0]    bin_q, bin_d;
    logic [BW-1:0]       bcd_q, bcd_d, bcd_adj;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                blank_q, blank_d;
    logic                ovf_q, ovf_d;
    logic                oflag_q, oflag_d;
    logic [7*DIGITS-1:0] seg_q, seg_d, seg_enc;
    logic                vld_q;
    logic [DIGITS-1:0]   lz_blank;

    always_comb begin
        bcd_adj = bcd_q;
        for (int k = 0; k < DIGITS; k++)
            if (bcd_q[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
    end

    // A digit is blanked only while every digit from it upward is zero
    always_comb begin
        logic run;
        run      = 1'b1;
        lz_blank = '0;
        for (int k = DIGITS - 1; k > 0; k--) begin
            run         = run & (bcd_q[4*k +: 4] == 4'd0);
            lz_blank[k] = blank_q & run;
        end
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_enc
        seg7_encode u_enc (
            .nib_i   (bcd_q[4*g +: 4]),
            .blank_i (lz_blank[g]),
            .seg_o   (seg_enc[7*g +: 7])
        );
    end

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        blank_d = blank_q;
        ovf_d   = ovf_q;
        oflag_d = oflag_q;
        seg_d   = seg_q;
        case (state_q)
            IDLE: if (bus.in_valid) begin
                bin_d   = bus.in_value;
                blank_d = bus.blank_lz;
                bcd_d   = '0;
                cnt_d   = '0;
                ovf_d   = 64'(bus.in_value) > MAX_VAL;
                state_d = ovf_d ? ENCODE : SHIFT;
            end
            SHIFT: begin
                {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
                if (cnt_q == CW'(WIDTH - 1)) state_d = ENCODE;
                else                         cnt_d   = cnt_q + 1'b1;
            end
            ENCODE: begin
                seg_d   = ovf_q ? {DIGITS{SEG_DASH}} : seg_enc;
                oflag_d = ovf_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            blank_q <= 1'b0;
            ovf_q   <= 1'b0;
            oflag_q <= 1'b0;
            seg_q   <= '1;
            vld_q   <= 1'b0;
        end else begin
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            blank_q <= blank_d;
            ovf_q   <= ovf_d;
            oflag_q <= oflag_d;
            seg_q   <= seg_d;
            vld_q   <= (state_q == ENCODE);
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.seg_out   = seg_q;
    assign bus.out_valid = vld_q;
    assign bus.overflow  = oflag_q;

endmodule

// File: tb/tb_hex_bcd_display_encoder.sv
// Scoreboarded random and directed stimulus for hex_bcd_display_encoder.
module tb_hex_bcd_display_encoder;
    localparam int WIDTH  = 16;
    localparam int DIGITS = 4;
    localparam logic [6:0] TBL [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                        7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    typedef struct {
        logic [27:0] seg;
        bit          ovf;
        time         t_acc;
        time         lat;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   total = 0;
    int   passed = 0;
    exp_t q[$];
    logic [27:0] prev_seg = '1;
    logic        prev_vld = 1'b0;

    hex_bcd_display_encoder_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus ();

    hex_bcd_display_encoder #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Decimal digits straight from division; blank above the value's magnitude
    function automatic logic [27:0] model(input int v, input bit blz);
        logic [27:0] s;
        int p;
        if (v > 9999) return {4{7'h3F}};
        p = 1;
        for (int k = 0; k < 4; k++) begin
            s[7*k +: 7] = (blz && k > 0 && v < p) ? 7'h7F : TBL[(v / p) % 10];
            p = p * 10;
        end
        return s;
    endfunction

    task automatic send(input int v, input bit blz);
        int   n;
        exp_t e;
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 100) begin @(negedge clk); n++; end
        if (!bus.in_ready) begin chk("ready_timeout", 0, 1); return; end
        bus.in_valid = 1'b1;
        bus.in_value = WIDTH'(v);
        bus.blank_lz = blz;
        @(posedge clk);
        e.seg   = model(v, blz);
        e.ovf   = (v > 9999);
        e.t_acc = $time;
        e.lat   = (v > 9999) ? 15 : 175;
        q.push_back(e);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 200) begin @(negedge clk); n++; end
        if (q.size() != 0) chk("drain_timeout", q.size(), 0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (bus.seg_out !== prev_seg) chk("seg_change_only_with_valid", bus.out_valid, 1);
                if (bus.out_valid) begin
                    chk("out_valid_one_cycle", prev_vld, 0);
                    if (q.size() == 0) chk("unexpected_out_valid", 1, 0);
                    else begin
                        e = q.pop_front();
                        chk("seg_out", bus.seg_out, e.seg);
                        chk("overflow", bus.overflow, e.ovf);
                        chk("latency", $time - e.t_acc, e.lat);
                    end
                end
            end
            prev_seg = bus.seg_out;
            prev_vld = bus.out_valid;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stim
        int v;
        bus.in_valid = 1'b0;
        bus.in_value = '0;
        bus.blank_lz = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("reset_seg", bus.seg_out, {28{1'b1}});
        chk("reset_valid", bus.out_valid, 0);
        chk("reset_ready", bus.in_ready, 1);
        chk("reset_ovf", bus.overflow, 0);

        send(1234, 0);
        send(42, 1);
        send(0, 1);
        send(7, 0);
        send(10000, 0);
        send(9999, 0);
        drain();

        // Input offered mid-conversion must be dropped
        send(8000, 0);
        repeat (3) @(negedge clk);
        chk("busy_not_ready", bus.in_ready, 0);
        bus.in_valid = 1'b1;
        bus.in_value = 16'd555;
        @(negedge clk);
        bus.in_valid = 1'b0;
        send(4321, 1);
        drain();

        send(9876, 0);
        repeat (8) @(negedge clk);
        chk("shift_not_ready", bus.in_ready, 0);
        reset_n = 1'b0;
        q.delete();
        #1;
        chk("abort_seg", bus.seg_out, {28{1'b1}});
        chk("abort_valid", bus.out_valid, 0);
        chk("abort_ready", bus.in_ready, 1);
        chk("abort_ovf", bus.overflow, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (25) @(negedge clk);
        send(321, 0);
        drain();

        for (int i = 0; i < 60; i++) begin
            v = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 65535))
                                            : int'($urandom_range(0, 10050));
            send(v, 1'($urandom_range(0, 1)));
        end
        send(9999, 1);
        send(10000, 1);
        send(0, 0);
        drain();

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
